// File: rtl/enigma_stream_sequencer_if.sv
// rtl/enigma_stream_sequencer_if.sv - character stream handshake bundle for the Enigma sequencer
//
// Purpose: groups the upstream (in_*) and downstream (out_*) valid/ready
// character streams of enigma_stream_sequencer.
//   in_char   [7:0]  ASCII character offered to the sequencer
//   in_valid         in_char is valid
//   in_ready         sequencer can accept a character
//   out_char  [7:0]  result character
//   out_valid        out_char is valid
//   out_ready        downstream accepts out_char
// Modports: master = stream source/sink side, slave = sequencer side.
interface enigma_stream_sequencer_if;
   logic [7:0] in_char;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_char;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output in_char, in_valid, out_ready,
      input  in_ready, out_char, out_valid
   );

   modport slave (
      input  in_char, in_valid, out_ready,
      output in_ready, out_char, out_valid
   );
endinterface

// File: rtl/enigma_stream_sequencer.sv
// rtl/enigma_stream_sequencer.sv - key-stepping control stage in front of the Enigma substitution core
//
// Purpose: accepts characters, drives letters with the current 2-bit key slot
// into the combinational substitution core, captures its result after
// WAIT_CYCLES and emits it downstream. Non-letters bypass the core and do not
// step the key.
// Parameters:
//   KEY_LEN      active key slots (1..4)
//   WAIT_CYCLES  cycles from driving the core to sampling core_out (1..15)
// Optional feature macro: ENIGMA_CASE_FOLD_EN (lowercase folded to uppercase
// and treated as a letter).
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start              pulse: load key, clear step and char_count, go to ACCEPT
//   key [7:0]          slot i = key[2i+1:2i]
//   s                  in/out character streams (slave modport)
//   core_char [7:0]    character driven to the core
//   core_setting [1:0] setting driven to the core
//   core_out [7:0]     core result
//   busy               high in WAIT or EMIT
//   char_count [15:0]  characters emitted since start, saturating
module enigma_stream_sequencer #(
   parameter int KEY_LEN     = 4,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [7:0]                 key,
   enigma_stream_sequencer_if.slave   s,
   output logic [7:0]                 core_char,
   output logic [1:0]                 core_setting,
   input  logic [7:0]                 core_out,
   output logic                       busy,
   output logic [15:0]                char_count
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCEPT = 2'd1,
      S_WAIT   = 2'd2,
      S_EMIT   = 2'd3
   } state_t;

   localparam logic [1:0] LAST_STEP = 2'(KEY_LEN - 1);
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   state_t     state;
   logic [7:0] key_q;
   logic [1:0] step;
   logic [3:0] wait_cnt;

   logic [7:0] acc_char;
   logic       acc_is_letter;
   logic [1:0] cur_slot;
   logic [1:0] next_step;

`ifdef ENIGMA_CASE_FOLD_EN
   assign acc_char = (s.in_char >= 8'h61 && s.in_char <= 8'h7A) ? (s.in_char - 8'h20) : s.in_char;
`else
   assign acc_char = s.in_char;
`endif

   assign acc_is_letter = (acc_char >= 8'h41) && (acc_char <= 8'h5A);
   assign cur_slot      = key_q[{step, 1'b0} +: 2];
   assign next_step     = (step == LAST_STEP) ? 2'd0 : step + 2'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         key_q       <= 8'h00;
         step        <= 2'd0;
         wait_cnt    <= 4'd0;
         s.in_ready  <= 1'b0;
         s.out_valid <= 1'b0;
         s.out_char  <= 8'h00;
         core_char   <= 8'h00;
         core_setting <= 2'd0;
         busy        <= 1'b0;
         char_count  <= 16'd0;
      end else if (start) begin
         // Start wins over any handshake; an in-flight character is dropped.
         state       <= S_ACCEPT;
         key_q       <= key;
         step        <= 2'd0;
         char_count  <= 16'd0;
         s.in_ready  <= 1'b1;
         s.out_valid <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               s.in_ready <= 1'b0;
            end

            S_ACCEPT: begin
               if (s.in_valid) begin
                  s.in_ready <= 1'b0;
                  busy       <= 1'b1;
                  if (acc_is_letter) begin
                     core_char    <= acc_char;
                     core_setting <= cur_slot;
                     wait_cnt     <= WAIT_LOAD;
                     state        <= S_WAIT;
                  end else begin
                     // Bypass: result is the raw character, step untouched.
                     s.out_char  <= s.in_char;
                     s.out_valid <= 1'b1;
                     state       <= S_EMIT;
                  end
               end
            end

            S_WAIT: begin
               if (wait_cnt == 4'd1) begin
                  s.out_char  <= core_out;
                  s.out_valid <= 1'b1;
                  step        <= next_step;
                  state       <= S_EMIT;
               end
               wait_cnt <= wait_cnt - 4'd1;
            end

            S_EMIT: begin
               if (s.out_ready) begin
                  if (char_count != 16'hFFFF) begin
                     char_count <= char_count + 16'd1;
                  end
                  s.out_valid <= 1'b0;
                  s.in_ready  <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_ACCEPT;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
